// File: rtl/down_counter_pkg.sv
// Shared constants for the down-counter timer: default width and state encoding.
package down_counter_pkg;
  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;
endpackage

// File: rtl/down_counter_timer.sv
// Loadable down counter with run/hold/done control, one-shot or periodic,
// and a single-cycle terminal-count strobe.
module down_counter_timer
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             re,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rld;
  logic [1:0]       r_state;
  logic             r_tc;

  logic w_q_one;
  logic w_q_zero;
  logic w_rld_zero;
  logic w_go;

  assign w_q_one    = (r_q == ONE);
  assign w_q_zero   = (r_q == ZERO);
  assign w_rld_zero = (r_rld == ZERO);
  // pause outranks start, so a simultaneous pause masks any start request
  assign w_go       = start & ~pause;

  always_ff @(posedge clk) begin
    if (re) begin
      r_q     <= ZERO;
      r_rld   <= ZERO;
      r_state <= ST_IDLE;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_q     <= din;
      r_rld   <= din;
      r_state <= ST_IDLE;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_go && !w_q_zero) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (pause) begin
            r_state <= ST_HOLD;
          end else if (w_q_one) begin
            r_tc <= 1'b1;
            if (auto_reload && !w_rld_zero) begin
              r_q <= r_rld;
            end else begin
              r_q     <= ZERO;
              r_state <= ST_DONE;
            end
          end else if (w_q_zero) begin
            // unreachable in normal use; park rather than wrap
            r_state <= ST_DONE;
          end else begin
            r_q <= r_q - ONE;
          end
        end
        ST_HOLD: begin
          if (w_go) r_state <= ST_RUN;
        end
        ST_DONE: begin
          if (w_go && !w_rld_zero) begin
            r_q     <= r_rld;
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign busy = (r_state == ST_RUN) || (r_state == ST_HOLD);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: reset, one-shot, periodic, pause,
// priority, mid-count reset and DONE re-arm scenarios.
module tb_down_counter_timer;
  logic       clk;
  logic       re;
  logic       load;
  logic [7:0] din;
  logic       start;
  logic       pause;
  logic       auto_reload;
  logic [7:0] q;
  logic       tc;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  down_counter_timer #(.WIDTH(8)) dut (
    .clk(clk), .re(re), .load(load), .din(din), .start(start), .pause(pause),
    .auto_reload(auto_reload), .q(q), .tc(tc), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic etc,
                         input logic ebusy, input logic edone);
    chk({tag, ".q"},    32'(q),    32'(eq));
    chk({tag, ".tc"},   32'(tc),   32'(etc));
    chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
    chk({tag, ".done"}, 32'(done), 32'(edone));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    re = 1'b1; load = 1'b0; din = 8'd0; start = 1'b0; pause = 1'b0; auto_reload = 1'b0;
    #2;
    tick(); tick();
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);

    // one-shot of 5
    re = 1'b0; load = 1'b1; din = 8'd5;
    tick(); chk_all("os_load", 8'd5, 1'b0, 1'b0, 1'b0);
    load = 1'b0; start = 1'b1;
    tick(); chk_all("os_start", 8'd5, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      tick(); chk_all("os_count", 8'(i), 1'b0, 1'b1, 1'b0);
    end
    tick(); chk_all("os_term", 8'd0, 1'b1, 1'b0, 1'b1);
    tick(); chk_all("os_after", 8'd0, 1'b0, 1'b0, 1'b1);

    // periodic, reload 3: 2,1,3,2,1,3,...
    load = 1'b1; din = 8'd3; auto_reload = 1'b1;
    tick(); load = 1'b0; start = 1'b1;
    tick(); chk_all("per_start", 8'd3, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (c % 3 == 2) chk_all("per_wrap", 8'd3, 1'b1, 1'b1, 1'b0);
      else            chk_all("per_count", 8'(2 - (c % 3)), 1'b0, 1'b1, 1'b0);
    end

    // periodic, reload 1: tc every cycle, q stays 1
    load = 1'b1; din = 8'd1;
    tick(); load = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(); chk_all("per1", 8'd1, 1'b1, 1'b1, 1'b0);
    end

    // pause/resume, one-shot of 10
    auto_reload = 1'b0; load = 1'b1; din = 8'd10;
    tick(); load = 1'b0; start = 1'b1;
    tick(); chk_all("pz_start", 8'd10, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    tick(); tick(); tick(); chk_all("pz_pre", 8'd7, 1'b0, 1'b1, 1'b0);
    pause = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) start = 1'b1;  // pause with start stays held
      tick(); chk_all("pz_hold", 8'd7, 1'b0, 1'b1, 1'b0);
    end
    pause = 1'b0; start = 1'b1;
    tick(); chk_all("pz_resume", 8'd7, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 6; i >= 1; i--) begin
      tick(); chk_all("pz_count", 8'(i), 1'b0, 1'b1, 1'b0);
    end
    tick(); chk_all("pz_term", 8'd0, 1'b1, 1'b0, 1'b1);

    // load on the terminal cycle wins and suppresses tc
    load = 1'b1; din = 8'd2;
    tick(); load = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk_all("pri_q1", 8'd1, 1'b0, 1'b1, 1'b0);
    load = 1'b1; din = 8'd9;
    tick(); chk_all("pri_load", 8'd9, 1'b0, 1'b0, 1'b0);
    load = 1'b1; din = 8'd0;
    tick(); load = 1'b0; start = 1'b1;
    tick(); chk_all("pri_zero_start", 8'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;

    // reset mid-count
    load = 1'b1; din = 8'd6;
    tick(); load = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); chk_all("rst_pre", 8'd4, 1'b0, 1'b1, 1'b0);
    re = 1'b1;
    tick(); chk_all("rst_mid", 8'd0, 1'b0, 1'b0, 1'b0);
    re = 1'b0; start = 1'b1;
    tick(); chk_all("rst_start", 8'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;

    // DONE re-arm with rld=2
    load = 1'b1; din = 8'd2;
    tick(); load = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); chk_all("rearm_done", 8'd0, 1'b1, 1'b0, 1'b1);
    start = 1'b1;
    tick(); chk_all("rearm_start", 8'd2, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    tick(); chk_all("rearm_q1", 8'd1, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("rearm_term", 8'd0, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Synchronous, loadable 8-bit down counter with run/hold/done control and a terminal-count pulse. It is the counting-down counterpart to the ripple up-counter. All state changes occur on the single clock, so it can time intervals and generate periodic ticks. Downstream logic uses `tc` as a strobe and `busy`/`done` as status.

## Interface
Parameters:
- WIDTH, 8, counter and load-value width.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- re  input  1  reset, synchronous, active-high.
- load  input  1  load `din` into counter and reload register.
- din  input  WIDTH  load value.
- start  input  1  begin, resume, or re-arm counting.
- pause  input  1  freeze counting while running.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, one cycle.
- busy  output  1  high in RUN or HOLD.
- done  output  1  high in DONE.

## Operation
- Registers: `q`, `rld` (reload value), `state` ∈ {IDLE, RUN, HOLD, DONE}, `tc`.
- Reset (`re`=1) sets `q`=0, `rld`=0, state=IDLE, `tc`=0, `busy`=0, `done`=0. Reset overrides every other input, including mid-count, and produces no `tc`.
- Priority order: `re` > `load` > `pause` > `start`.
- `load`, in any state:
  - `q`←`din`, `rld`←`din`, state←IDLE.
  - Suppresses any `tc` that would have fired that cycle.
- IDLE:
  - `start` with `q`≠0 → RUN.
  - `start` with `q`=0 is ignored; state stays IDLE.
  - No decrement occurs on the transition cycle.
- RUN, `pause`=1: no decrement, → HOLD.
- RUN, `q`>1: `q`←`q`−1.
- RUN, `q`=1 (terminal decrement):
  - `tc`←1.
  - If `auto_reload`=1 and `rld`≠0: `q`←`rld`, stay in RUN. In this mode `q` never shows 0.
  - Otherwise: `q`←0, → DONE.
- `auto_reload` is sampled only on the terminal-decrement cycle.
- HOLD:
  - `q` is frozen.
  - `start`=1 and `pause`=0 → RUN.
  - `pause` and `start` together: stay in HOLD.
- DONE:
  - `start` with `rld`≠0: `q`←`rld`, → RUN.
  - `start` with `rld`=0: stay in DONE.
- `tc` is 0 on every cycle except those listed above.
- Arithmetic is unsigned, WIDTH bits. The counter never wraps below 0, because the terminal decrement is always 1→0 or 1→`rld`.

## Timing
- All outputs are registered. `busy` and `done` are decoded from the state register, with no combinational path from inputs.
- Start-to-first-decrement latency: `start` sampled at edge k → RUN after edge k → first decrement at edge k+1.
- One-shot with `din`=N≥1: `start` at edge k → `tc` high for the cycle after edge k+N, coincident with `q`=0 and `done`=1.
- Periodic mode with `rld`=N: `tc` pulses once every N cycles. N=1 gives `tc` high every cycle.
- Pause: each cycle spent in HOLD delays `tc` by one cycle. The resume cycle (HOLD→RUN) also delays `tc` by one cycle, since no decrement occurs on it.

## Structure
- Shared package `down_counter_pkg` holds:
  - default WIDTH;
  - state encoding: IDLE=2'b00, RUN=2'b01, HOLD=2'b10, DONE=2'b11.
- Single module with no sub-module. The decrement datapath and FSM are inline; `q` and `tc` update in one clocked process.

## Test plan
- Reset/one-shot: `re` for 2 cycles → all outputs 0. Load 5, `start` → `q` goes 5,4,3,2,1,0 on successive edges; `tc`=1 for exactly one cycle with `q`=0; `done`=1, `busy`=0.
- Periodic: load 3, `auto_reload`=1, `start` → `q` cycles 3,2,1,3,2,1…; `tc` every 3 cycles; `done` never asserts.
- Pause/resume: load 10, `start`, `pause` after `q`=7 for 4 cycles → `q` holds 7, `busy`=1. `start` → decrement resumes one cycle later; `tc` is delayed 5 cycles versus the unpaused run.
- Priority corner: `load` of 9 on the same cycle `q`=1 in RUN → `q`=9, state IDLE, `tc` stays 0. `start` with `q`=0 in IDLE → no state change.
- Reset mid-count: `re` asserted while RUN with `q`=4 → next edge `q`=0, IDLE, `tc`=0, `rld`=0.
- DONE re-arm: after a one-shot of 2, `start` → `q`=2, RUN, `tc` after 2 more edges. After reset then `start` (`rld`=0) → state stays IDLE.
